fp_issue_sched: RTL and testbench
=================================

# fp_issue_sched

Issue scheduler for the two non-pipelined FP execution units (fp_add, fp_mul) in the EX stage. It accepts FP arithmetic ops from D/X and decides when each may start. It stalls the front end on unit-busy, RAW/WAW conflicts with in-flight results, and writeback-port collisions. It then sequences the single FP writeback port when each unit's latency expires.

## Interface
Parameters:
- ADD_LAT, 3, fp_add latency in cycles (1..14)
- MUL_LAT, 5, fp_mul latency in cycles (1..14)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  D/X holds an FP arithmetic op (add.s/mul.s)
- issue_op  in  1  0 = add.s, 1 = mul.s
- issue_fs  in  5  FP source register 1
- issue_ft  in  5  FP source register 2
- issue_fd  in  5  FP destination register
- issue_stall  out  1  combinational; op in D/X must be held
- add_go  out  1  combinational; start pulse to fp_add
- mul_go  out  1  combinational; start pulse to fp_mul
- add_busy  out  1  add_cnt != 0
- mul_busy  out  1  mul_cnt != 0
- pending  out  32  scoreboard; bit r = FP reg r awaits result
- wb_valid  out  1  registered; one-cycle FP writeback strobe
- wb_sel  out  1  registered; 0 = take fp_add result, 1 = fp_mul
- wb_fd  out  5  registered; writeback destination

## Operation
- State: add_cnt and mul_cnt (4-bit down-counters), add_fd and mul_fd (5-bit), pending[31:0], and the wb_* registers.
- The op's unit is U, with latency LAT; the other unit is V, with counter cnt_V.
- issue_stall = rst, or (issue_valid and any of the following):
  - cnt_U != 0 (unit busy)
  - pending[issue_fs] or pending[issue_ft] (RAW)
  - pending[issue_fd] (WAW)
  - cnt_V == LAT+1 (writeback collision)
- An op is accepted when issue_valid and !issue_stall. In the accept cycle the matching add_go/mul_go is high.
- At the accept edge: cnt_U <= LAT, U_fd <= issue_fd, pending[issue_fd] <= 1.
- Each edge with cnt != 0: cnt decrements.
- On the 1->0 edge: wb_valid <= 1, wb_sel <= unit, wb_fd <= U_fd, pending[U_fd] <= 0. wb_valid otherwise returns to 0 on the next edge.
- The collision rule guarantees at most one completion per edge. Dual completion is illegal and must be caught by a bench assertion.
- WAW stall guarantees the set and clear of the same pending bit never coincide.
- fs/ft/fd compare on all 5 bits; register 0 is not special-cased.
- Reset mid-operation:
  - clears counters, pending, wb_valid/wb_sel/wb_fd, add_fd/mul_fd to 0
  - in-flight results are discarded with no wb_valid
  - issue_stall=1 while rst is high

## Timing
- Reset values: add_busy=0, mul_busy=0, pending=0, wb_valid=0, wb_sel=0, wb_fd=0, add_go=0, mul_go=0, issue_stall=1.
- Op accepted in cycle t: wb_valid is high in cycle t+LAT+1, for exactly one cycle.
- Unit counter during cycle t+k is LAT-k+1 for k=1..LAT.
- The same unit can accept again in cycle t+LAT+1, while the previous wb_valid is high.
- RAW on a completing register releases in the cycle wb_valid is high. That same-cycle data is supplied by downstream forwarding, not by this block.
- issue_stall, add_go and mul_go are purely combinational from inputs and state; no registered lag.

## Test plan
- Single add: ADD_LAT=3, add.s fd=3 in cycle 0.
  - add_go=1 in cycle 0; pending[3]=1 in cycles 1-3.
  - wb_valid=1, wb_sel=0, wb_fd=3 in cycle 4; pending[3]=0 in cycle 4.
- RAW: mul.s fd=5 in cycle 0, then add.s fs=5 valid from cycle 1.
  - issue_stall=1 in cycles 1-5; add accepted in cycle 6 alongside the mul wb_valid.
- Structural: add.s fd=1 in cycle 0, then add.s fd=2 valid from cycle 1.
  - Stall in cycles 1-3; second add_go in cycle 4; wb_fd=1 in cycle 4, wb_fd=2 in cycle 8.
- Writeback collision: mul.s fd=1 in cycle 0, then add.s fd=2 in cycle 2 (mul_cnt=4).
  - Stall in cycle 2; add accepted in cycle 3.
  - wb mul in cycle 6, wb add in cycle 7; never two strobes in one cycle.
- WAW: add.s fd=7 in cycle 0, then mul.s fd=7 from cycle 1.
  - Stall in cycles 1-3; mul_go in cycle 4; final wb_fd=7, wb_sel=1 in cycle 10.
- Reset mid-op: mul.s in cycle 0, rst high in cycles 2-3.
  - All outputs return to reset values; no wb_valid ever appears.
  - add.s issued in cycle 4 is accepted immediately and completes in cycle 8.

Source files
------------

// File: rtl/fp_issue_sched.sv
// Issue scheduler for the non-pipelined fp_add/fp_mul units: hazard/structural stalls,
// pending-register scoreboard, and sequencing of the single shared FP writeback port.
module fp_issue_sched #(
   parameter int unsigned ADD_LAT = 3,
   parameter int unsigned MUL_LAT = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic        issue_op,
   input  logic [4:0]  issue_fs,
   input  logic [4:0]  issue_ft,
   input  logic [4:0]  issue_fd,
   output logic        issue_stall,
   output logic        add_go,
   output logic        mul_go,
   output logic        add_busy,
   output logic        mul_busy,
   output logic [31:0] pending,
   output logic        wb_valid,
   output logic        wb_sel,
   output logic [4:0]  wb_fd
);

   localparam logic [3:0] ADD_LAT_C = 4'(ADD_LAT);
   localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);

   logic [3:0]  r_add_cnt, r_mul_cnt;
   logic [4:0]  r_add_fd, r_mul_fd;
   logic [31:0] r_pending;
   logic        r_wb_valid, r_wb_sel;
   logic [4:0]  r_wb_fd;

   logic [3:0]  w_cnt_u, w_cnt_v, w_lat, w_lat_p1;
   logic        w_conflict, w_accept, w_add_done, w_mul_done;
   logic [31:0] w_pending_d;

   always_comb begin
      w_cnt_u  = issue_op ? r_mul_cnt : r_add_cnt;
      w_cnt_v  = issue_op ? r_add_cnt : r_mul_cnt;
      w_lat    = issue_op ? MUL_LAT_C : ADD_LAT_C;
      w_lat_p1 = w_lat + 4'd1;
      // Last term: the other unit would finish on the same edge as this op.
      w_conflict = (w_cnt_u != 4'd0) | r_pending[issue_fs] | r_pending[issue_ft]
                 | r_pending[issue_fd] | (w_cnt_v == w_lat_p1);
      issue_stall = rst | (issue_valid & w_conflict);
      w_accept    = issue_valid & ~issue_stall;
      add_go      = w_accept & ~issue_op;
      mul_go      = w_accept & issue_op;
   end

   assign w_add_done = (r_add_cnt == 4'd1);
   assign w_mul_done = (r_mul_cnt == 4'd1);

   always_comb begin
      w_pending_d = r_pending;
      if (w_add_done) w_pending_d[r_add_fd] = 1'b0;
      if (w_mul_done) w_pending_d[r_mul_fd] = 1'b0;
      if (w_accept)   w_pending_d[issue_fd] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_add_cnt  <= 4'd0;
         r_mul_cnt  <= 4'd0;
         r_add_fd   <= 5'd0;
         r_mul_fd   <= 5'd0;
         r_pending  <= 32'd0;
         r_wb_valid <= 1'b0;
         r_wb_sel   <= 1'b0;
         r_wb_fd    <= 5'd0;
      end else begin
         if (add_go) begin
            r_add_cnt <= ADD_LAT_C;
            r_add_fd  <= issue_fd;
         end else if (r_add_cnt != 4'd0) begin
            r_add_cnt <= r_add_cnt - 4'd1;
         end
         if (mul_go) begin
            r_mul_cnt <= MUL_LAT_C;
            r_mul_fd  <= issue_fd;
         end else if (r_mul_cnt != 4'd0) begin
            r_mul_cnt <= r_mul_cnt - 4'd1;
         end
         r_pending  <= w_pending_d;
         r_wb_valid <= w_add_done | w_mul_done;
         if (w_mul_done) begin
            r_wb_sel <= 1'b1;
            r_wb_fd  <= r_mul_fd;
         end else if (w_add_done) begin
            r_wb_sel <= 1'b0;
            r_wb_fd  <= r_add_fd;
         end
      end
   end

   assign add_busy = (r_add_cnt != 4'd0);
   assign mul_busy = (r_mul_cnt != 4'd0);
   assign pending  = r_pending;
   assign wb_valid = r_wb_valid;
   assign wb_sel   = r_wb_sel;
   assign wb_fd    = r_wb_fd;

endmodule

// File: tb/tb_fp_issue_sched.sv
// Directed, table-driven bench for fp_issue_sched with ADD_LAT=3, MUL_LAT=5.
module tb_fp_issue_sched;

   localparam int unsigned ADD_LAT = 3;
   localparam int unsigned MUL_LAT = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_op;
   logic [4:0]  issue_fs, issue_ft, issue_fd;
   logic        issue_stall, add_go, mul_go, add_busy, mul_busy;
   logic [31:0] pending;
   logic        wb_valid, wb_sel;
   logic [4:0]  wb_fd;

   int n_tests = 0;
   int n_fail  = 0;

   fp_issue_sched #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_op(issue_op),
      .issue_fs(issue_fs), .issue_ft(issue_ft), .issue_fd(issue_fd),
      .issue_stall(issue_stall), .add_go(add_go), .mul_go(mul_go),
      .add_busy(add_busy), .mul_busy(mul_busy), .pending(pending),
      .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_fd(wb_fd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, v, op;
      logic [4:0]  fs, ft, fd;
      logic        stall, ag, mg, ab, mb, wbv, wsel;
      logic [4:0]  wfd;
      logic [31:0] pend;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int r, int v, int op, int fs, int ft, int fd,
                               int st, int ag, int mg, int ab, int mb,
                               int wbv, int wsel, int wfd, int pend);
      vec_t x;
      x.rst = 1'(r);    x.v = 1'(v);     x.op = 1'(op);
      x.fs = 5'(fs);    x.ft = 5'(ft);   x.fd = 5'(fd);
      x.stall = 1'(st); x.ag = 1'(ag);   x.mg = 1'(mg);
      x.ab = 1'(ab);    x.mb = 1'(mb);   x.wbv = 1'(wbv);
      x.wsel = 1'(wsel); x.wfd = 5'(wfd); x.pend = 32'(pend);
      return x;
   endfunction

   task automatic push(int n, vec_t x);
      for (int i = 0; i < n; i++) vecs.push_back(x);
   endtask

   task automatic idle(int n, int ab, int mb, int wbv, int wsel, int wfd, int pend);
      push(n, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ab, mb, wbv, wsel, wfd, pend));
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Both units finishing on the same edge would need two writeback strobes.
   always @(negedge clk) begin
      if (!rst) begin
         assert (!(dut.r_add_cnt == 4'd1 && dut.r_mul_cnt == 4'd1))
         else begin
            n_fail++;
            $display("FAIL dual_completion: got both units finishing at %0t expected one", $time);
         end
      end
   end

   initial begin
      int lat;
      bit found;

      // Single add fd=3
      push(1, mk(0, 1, 0, 1, 2, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      idle(3, 1, 0, 0, 0, 0, 32'h8);
      idle(1, 0, 0, 1, 0, 3, 0);
      idle(1, 0, 0, 0, 0, 0, 0);
      // RAW: mul fd=5, add fs=5 waits for the mul writeback
      push(1, mk(0, 1, 1, 10, 11, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      push(5, mk(0, 1, 0, 5, 6, 8, 1, 0, 0, 0, 1, 0, 0, 0, 32'h20));
      push(1, mk(0, 1, 0, 5, 6, 8, 0, 1, 0, 0, 0, 1, 1, 5, 0));
      idle(3, 1, 0, 0, 0, 0, 32'h100);
      idle(1, 0, 0, 1, 0, 8, 0);
      // Structural: back-to-back adds
      push(1, mk(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      push(3, mk(0, 1, 0, 3, 4, 2, 1, 0, 0, 1, 0, 0, 0, 0, 32'h2));
      push(1, mk(0, 1, 0, 3, 4, 2, 0, 1, 0, 0, 0, 1, 0, 1, 0));
      idle(3, 1, 0, 0, 0, 0, 32'h4);
      idle(1, 0, 0, 1, 0, 2, 0);
      // Writeback collision: add blocked while mul_cnt == ADD_LAT+1
      push(1, mk(0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      idle(1, 0, 1, 0, 0, 0, 32'h2);
      push(1, mk(0, 1, 0, 3, 4, 2, 1, 0, 0, 0, 1, 0, 0, 0, 32'h2));
      push(1, mk(0, 1, 0, 3, 4, 2, 0, 1, 0, 0, 1, 0, 0, 0, 32'h2));
      idle(2, 1, 1, 0, 0, 0, 32'h6);
      idle(1, 1, 0, 1, 1, 1, 32'h4);
      idle(1, 0, 0, 1, 0, 2, 0);
      idle(1, 0, 0, 0, 0, 0, 0);
      // WAW: mul fd=7 behind add fd=7
      push(1, mk(0, 1, 0, 0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      push(3, mk(0, 1, 1, 1, 2, 7, 1, 0, 0, 1, 0, 0, 0, 0, 32'h80));
      push(1, mk(0, 1, 1, 1, 2, 7, 0, 0, 1, 0, 0, 1, 0, 7, 0));
      idle(5, 0, 1, 0, 0, 0, 32'h80);
      idle(1, 0, 0, 1, 1, 7, 0);
      // Reset mid-op: mul fd=9 discarded, add during reset is refused
      push(1, mk(0, 1, 1, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      idle(1, 0, 1, 0, 0, 0, 32'h200);
      push(1, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      push(1, mk(1, 1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      push(1, mk(0, 1, 0, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      idle(3, 1, 0, 0, 0, 0, 32'h10);
      idle(1, 0, 0, 1, 0, 4, 0);
      idle(1, 0, 0, 0, 0, 0, 0);

      rst = 1'b1; issue_valid = 1'b0; issue_op = 1'b0;
      issue_fs = 5'd0; issue_ft = 5'd0; issue_fd = 5'd0;
      #2;
      check("reset_stall",    32'(issue_stall), 32'd1);
      check("reset_add_go",   32'(add_go),      32'd0);
      check("reset_mul_go",   32'(mul_go),      32'd0);
      check("reset_add_busy", 32'(add_busy),    32'd0);
      check("reset_mul_busy", 32'(mul_busy),    32'd0);
      check("reset_pending",  pending,          32'd0);
      check("reset_wb_valid", 32'(wb_valid),    32'd0);
      check("reset_wb_sel",   32'(wb_sel),      32'd0);
      check("reset_wb_fd",    32'(wb_fd),       32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (vecs[i]) begin
         rst = vecs[i].rst; issue_valid = vecs[i].v; issue_op = vecs[i].op;
         issue_fs = vecs[i].fs; issue_ft = vecs[i].ft; issue_fd = vecs[i].fd;
         #4;
         check($sformatf("row%0d_stall", i),    32'(issue_stall), 32'(vecs[i].stall));
         check($sformatf("row%0d_add_go", i),   32'(add_go),      32'(vecs[i].ag));
         check($sformatf("row%0d_mul_go", i),   32'(mul_go),      32'(vecs[i].mg));
         check($sformatf("row%0d_add_busy", i), 32'(add_busy),    32'(vecs[i].ab));
         check($sformatf("row%0d_mul_busy", i), 32'(mul_busy),    32'(vecs[i].mb));
         check($sformatf("row%0d_pending", i),  pending,          vecs[i].pend);
         check($sformatf("row%0d_wb_valid", i), 32'(wb_valid),    32'(vecs[i].wbv));
         if (vecs[i].wbv || vecs[i].rst) begin
            check($sformatf("row%0d_wb_sel", i), 32'(wb_sel), 32'(vecs[i].wsel));
            check($sformatf("row%0d_wb_fd", i),  32'(wb_fd),  32'(vecs[i].wfd));
         end
         @(posedge clk); #1;
      end

      // Bounded wait: mul latency measured from the accept cycle
      rst = 1'b0; issue_valid = 1'b1; issue_op = 1'b1;
      issue_fs = 5'd20; issue_ft = 5'd21; issue_fd = 5'd12;
      #4;
      check("seq_mul_go", 32'(mul_go), 32'd1);
      found = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20 && !found; k++) begin
         @(posedge clk); #1;
         issue_valid = 1'b0;
         #4;
         if (wb_valid) begin
            found = 1'b1;
            lat = k;
         end
      end
      check("seq_mul_latency", found ? 32'(lat) : 32'hdead, 32'(MUL_LAT + 1));
      check("seq_wb_sel", 32'(wb_sel), 32'd1);
      check("seq_wb_fd",  32'(wb_fd),  32'd12);
      @(posedge clk); #5;
      check("seq_wb_drop", 32'(wb_valid), 32'd0);
      check("seq_pending", pending, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
